sgm_path_aggregator_lr: RTL and testbench

- Left-to-right SGM path-cost aggregation stage, one pixel per cycle, directly upstream of argmin.
- Consumes the per-pixel matching-cost vector C(p,d) for all disparities.
- Produces the aggregated path-cost vector L(p,d) = C(p,d) + min(L(p-1,d), L(p-1,d±1)+P1, minL(p-1)+P2) - minL(p-1).
- Output is packed in the same word order argmin expects, so it can be summed with other paths or fed straight to argmin.

---
 rtl/sgm_path_aggregator_lr_pkg.sv | 14 +
 rtl/sgm_path_aggregator_lr_argmin.sv | 17 +
 rtl/sgm_path_aggregator_lr.sv | 129 ++++++++++++
 tb/tb_sgm_path_aggregator_lr.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgm_path_aggregator_lr_pkg.sv
// Shared constants and helpers for the SGM path-aggregation stages (all path directions).
package sgm_path_aggregator_lr_pkg;

  localparam int unsigned SGM_P1_DEFAULT = 1;
  localparam int unsigned SGM_P2_DEFAULT = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sgm_path_aggregator_lr_argmin.sv
// Combinational minimum over INPUTS packed WIDTH-bit words (word i at [WIDTH*i +: WIDTH]).
module sgm_path_aggregator_lr_argmin #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned INPUTS = 8
) (
  input  logic [INPUTS*WIDTH-1:0] vals_i,
  output logic [WIDTH-1:0]        min_o
);

  always_comb begin
    min_o = vals_i[WIDTH-1:0];
    for (int unsigned i = 1; i < INPUTS; i++) begin
      if (vals_i[i*WIDTH +: WIDTH] < min_o) min_o = vals_i[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/sgm_path_aggregator_lr.sv
// Left-to-right SGM path-cost aggregation, one pixel/cycle, 2-cycle latency.
// SGM_AGG_SATURATE_EN: clamp each L word at 2^ACC_WIDTH-1 instead of wrapping.
module sgm_path_aggregator_lr
  import sgm_path_aggregator_lr_pkg::*;
#(
  parameter int unsigned COST_WIDTH  = 6,
  parameter int unsigned ACC_WIDTH   = 8,
  parameter int unsigned DISPARITIES = 8,
  parameter int unsigned P1          = SGM_P1_DEFAULT,
  parameter int unsigned P2          = SGM_P2_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic                              in_first,
  input  logic [DISPARITIES*COST_WIDTH-1:0] in_costs,
  output logic                              out_valid,
  output logic                              out_first,
  output logic [DISPARITIES*ACC_WIDTH-1:0]  out_costs,
  output logic [ACC_WIDTH-1:0]              out_min
);

  localparam int unsigned AW = ACC_WIDTH;
  localparam int unsigned CW = COST_WIDTH;
  localparam int unsigned D  = DISPARITIES;
  localparam logic [AW:0] P1_X = (AW+1)'(P1);
  localparam logic [AW:0] P2_X = (AW+1)'(P2);
`ifdef SGM_AGG_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  if (D < 2 || (1 << clog2(D)) != D) begin : g_bad_disp
    $error("DISPARITIES must be a power of two >= 2");
  end
  if (AW < CW) begin : g_bad_width
    $error("ACC_WIDTH must be >= COST_WIDTH");
  end

  logic          s1_valid_q, s1_first_q;
  logic [D*AW-1:0] s1_costs_q, costs_ext;
  logic          out_valid_q, out_first_q, have_prev_q;
  logic [D*AW-1:0] out_costs_q, out_costs_d;
  logic [AW-1:0]   out_min_q, out_min_d;
  logic          restart;
  logic [AW:0]     min_prev_x;

  for (genvar d = 0; d < D; d++) begin : g_ext
    assign costs_ext[d*AW +: AW] = AW'(in_costs[d*CW +: CW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_costs_q <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_first_q <= in_valid & in_first;
      if (in_valid) s1_costs_q <= costs_ext;
    end
  end

  assign restart    = s1_first_q | ~have_prev_q;
  assign min_prev_x = {1'b0, out_min_q};

  // Edge disparities simply omit the missing neighbour candidate.
  for (genvar d = 0; d < D; d++) begin : g_lane
    logic [AW:0] l_self, best0, best1, best, l_sum;
    logic [AW-1:0] l_red;

    assign l_self = {1'b0, out_costs_q[d*AW +: AW]};
    assign best0  = (l_self < min_prev_x + P2_X) ? l_self : min_prev_x + P2_X;

    if (d > 0) begin : g_lo
      logic [AW:0] l_lo;
      assign l_lo  = {1'b0, out_costs_q[(d-1)*AW +: AW]} + P1_X;
      assign best1 = (l_lo < best0) ? l_lo : best0;
    end else begin : g_lo_none
      assign best1 = best0;
    end

    if (d < D-1) begin : g_hi
      logic [AW:0] l_hi;
      assign l_hi = {1'b0, out_costs_q[(d+1)*AW +: AW]} + P1_X;
      assign best = (l_hi < best1) ? l_hi : best1;
    end else begin : g_hi_none
      assign best = best1;
    end

    // best >= min_prev, so the subtraction cannot go negative.
    assign l_sum = best - min_prev_x + {1'b0, s1_costs_q[d*AW +: AW]};
    assign l_red = (SAT_EN && l_sum[AW]) ? '1 : l_sum[AW-1:0];
    assign out_costs_d[d*AW +: AW] = restart ? s1_costs_q[d*AW +: AW] : l_red;
  end

  sgm_path_aggregator_lr_argmin #(
    .WIDTH  (AW),
    .INPUTS (D)
  ) u_min (
    .vals_i (out_costs_d),
    .min_o  (out_min_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_costs_q <= '0;
      out_min_q   <= '0;
      have_prev_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      out_first_q <= s1_first_q;
      if (s1_valid_q) begin
        out_costs_q <= out_costs_d;
        out_min_q   <= out_min_d;
        have_prev_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_costs = out_costs_q;
  assign out_min   = out_min_q;

endmodule

// File: tb/tb_sgm_path_aggregator_lr.sv
// Bench for sgm_path_aggregator_lr: directed table, random vs. reference model, reset and wrap/clamp cases.
module tb_sgm_path_aggregator_lr;

  localparam int D   = 4;
  localparam int CW  = 6;
  localparam int AW  = 8;
  localparam int SAW = 6;
  localparam int P1  = 1;
  localparam int P2  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_first;
  logic [D*CW-1:0] in_costs;
  logic out_valid, out_first;
  logic [D*AW-1:0] out_costs;
  logic [AW-1:0] out_min;

  logic s_valid, s_first;
  logic [D*CW-1:0] s_costs;
  logic s_out_valid, s_out_first;
  logic [D*SAW-1:0] s_out_costs;
  logic [SAW-1:0] s_out_min;

  always #5 clk = ~clk;

  sgm_path_aggregator_lr #(
    .COST_WIDTH(CW), .ACC_WIDTH(AW), .DISPARITIES(D), .P1(P1), .P2(P2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_costs(in_costs),
    .out_valid(out_valid), .out_first(out_first), .out_costs(out_costs), .out_min(out_min)
  );

  sgm_path_aggregator_lr #(
    .COST_WIDTH(CW), .ACC_WIDTH(SAW), .DISPARITIES(D), .P1(P1), .P2(P2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_first(s_first), .in_costs(s_costs),
    .out_valid(s_out_valid), .out_first(s_out_first), .out_costs(s_out_costs), .out_min(s_out_min)
  );

  typedef struct packed {
    logic                 v;
    logic                 f;
    logic [D-1:0][AW-1:0] c;
    logic [AW-1:0]        mn;
  } exp_t;

  typedef struct packed {
    logic                 v;
    logic                 f;
    logic [D-1:0][CW-1:0] ci;
    exp_t                 e;
  } vec_t;

  exp_t pipe[$];
  vec_t tbl[12];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: previous path-cost vector, its minimum, row-in-progress flag.
  int m_L[D];
  int m_min;
  bit m_have;

  function automatic logic [D-1:0][CW-1:0] pc(input int a, input int b, input int c, input int d);
    logic [D-1:0][CW-1:0] r;
    r[0] = CW'(a); r[1] = CW'(b); r[2] = CW'(c); r[3] = CW'(d);
    return r;
  endfunction

  function automatic logic [D-1:0][AW-1:0] pa(input int a, input int b, input int c, input int d);
    logic [D-1:0][AW-1:0] r;
    r[0] = AW'(a); r[1] = AW'(b); r[2] = AW'(c); r[3] = AW'(d);
    return r;
  endfunction

  function automatic exp_t ex(input logic v, input logic f, input logic [D-1:0][AW-1:0] c, input int mn);
    exp_t e;
    e.v = v; e.f = f; e.c = c; e.mn = AW'(mn);
    return e;
  endfunction

  function automatic vec_t mkv(input logic v, input logic f, input logic [D-1:0][CW-1:0] ci, input exp_t e);
    vec_t t;
    t.v = v; t.f = f; t.ci = ci; t.e = e;
    return t;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < D; d++) m_L[d] = 0;
    m_min  = 0;
    m_have = 1'b0;
  endfunction

  // L(p,d) = C + min(L(d), L(d-1)+P1, L(d+1)+P1, minL+P2) - minL, wrapped or clamped to AW bits.
  function automatic exp_t model_step(input logic v, input logic f, input logic [D-1:0][CW-1:0] c);
    int   nl[D];
    int   best;
    int   top;
    exp_t e;
    top = (1 << AW) - 1;
    if (v) begin
      for (int d = 0; d < D; d++) begin
        if (f || !m_have) begin
          nl[d] = int'(c[d]);
        end else begin
          best = m_L[d];
          if (d > 0 && m_L[d-1] + P1 < best) best = m_L[d-1] + P1;
          if (d < D-1 && m_L[d+1] + P1 < best) best = m_L[d+1] + P1;
          if (m_min + P2 < best) best = m_min + P2;
          nl[d] = int'(c[d]) + best - m_min;
`ifdef SGM_AGG_SATURATE_EN
          if (nl[d] > top) nl[d] = top;
`else
          nl[d] = nl[d] % (top + 1);
`endif
        end
      end
      m_min = nl[0];
      for (int d = 0; d < D; d++) begin
        m_L[d] = nl[d];
        if (nl[d] < m_min) m_min = nl[d];
      end
      m_have = 1'b1;
    end
    e.v = v;
    e.f = v & f;
    for (int d = 0; d < D; d++) e.c[d] = AW'(m_L[d]);
    e.mn = AW'(m_min);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (pipe.size() >= 2) begin
      e = pipe.pop_front();
      check("out_valid", int'(out_valid), int'(e.v));
      if (e.v) check("out_first", int'(out_first), int'(e.f));
      for (int d = 0; d < D; d++)
        check($sformatf("out_costs[%0d]", d), int'(out_costs[d*AW +: AW]), int'(e.c[d]));
      check("out_min", int'(out_min), int'(e.mn));
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [D-1:0][CW-1:0] c, input exp_t e);
    @(negedge clk);
    compare_front();
    in_valid = v;
    in_first = f;
    in_costs = c;
    pipe.push_back(e);
  endtask

  task automatic step_model(input logic v, input logic f, input logic [D-1:0][CW-1:0] c);
    exp_t e;
    e = model_step(v, f, c);
    drive(v, f, c, e);
  endtask

  task automatic flush();
    repeat (2) step_model(1'b0, 1'b0, '0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_first"}, int'(out_first), 0);
    for (int d = 0; d < D; d++)
      check($sformatf("%s_costs[%0d]", tag, d), int'(out_costs[d*AW +: AW]), 0);
    check({tag, "_min"}, int'(out_min), 0);
  endtask

  task automatic random_run(input int n);
    logic [D-1:0][CW-1:0] c;
    logic v, f;
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < D; d++) c[d] = CW'($urandom_range(0, (1 << CW) - 1));
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0);
      step_model(v, f, c);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dummy;
    rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_costs = '0;
    s_valid = 1'b0;  s_first = 1'b0;  s_costs = '0;
    model_reset();

    tbl[0]  = mkv(1, 1, pc(5, 3, 7, 2),     ex(1, 1, pa(5, 3, 7, 2), 2));
    tbl[1]  = mkv(1, 0, pc(0, 0, 0, 0),     ex(1, 0, pa(2, 1, 1, 0), 0));
    tbl[2]  = mkv(1, 1, pc(5, 3, 7, 2),     ex(1, 1, pa(5, 3, 7, 2), 2));
    tbl[3]  = mkv(0, 0, pc(11, 22, 33, 44), ex(0, 0, pa(5, 3, 7, 2), 2));
    tbl[4]  = mkv(0, 0, pc(11, 22, 33, 44), ex(0, 0, pa(5, 3, 7, 2), 2));
    tbl[5]  = mkv(0, 0, pc(11, 22, 33, 44), ex(0, 0, pa(5, 3, 7, 2), 2));
    tbl[6]  = mkv(1, 0, pc(0, 0, 0, 0),     ex(1, 0, pa(2, 1, 1, 0), 0));
    tbl[7]  = mkv(0, 1, pc(9, 9, 9, 9),     ex(0, 0, pa(2, 1, 1, 0), 0));
    tbl[8]  = mkv(1, 0, pc(3, 3, 3, 3),     ex(1, 0, pa(5, 4, 4, 3), 3));
    tbl[9]  = mkv(1, 1, pc(9, 9, 9, 9),     ex(1, 1, pa(9, 9, 9, 9), 9));
    tbl[10] = mkv(1, 1, pc(0, 40, 40, 40),  ex(1, 1, pa(0, 40, 40, 40), 0));
    tbl[11] = mkv(1, 0, pc(0, 0, 0, 0),     ex(1, 0, pa(0, 1, 8, 8), 0));

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      dummy = model_step(tbl[i].v, tbl[i].f, tbl[i].ci);
      drive(tbl[i].v, tbl[i].f, tbl[i].ci, tbl[i].e);
    end
    flush();

    random_run(300);

    // Reset in the middle of a row: outputs clear asynchronously.
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_zero_outputs("midrst");
    pipe.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    dummy = model_step(1'b1, 1'b0, pc(4, 4, 4, 4));
    drive(1'b1, 1'b0, pc(4, 4, 4, 4), ex(1, 0, pa(4, 4, 4, 4), 4));
    random_run(300);
    flush();

    // Narrow-accumulator instance: overflow of the AW+1-bit result.
    @(negedge clk);
    s_valid = 1'b1; s_first = 1'b1; s_costs = pc(63, 63, 63, 0);
    @(negedge clk);
    s_first = 1'b0; s_costs = pc(63, 63, 63, 63);
    @(negedge clk);
    s_valid = 1'b0;
    check("sat_row_valid", int'(s_out_valid), 1);
    check("sat_row_first", int'(s_out_first), 1);
    check("sat_row_d0", int'(s_out_costs[0 +: SAW]), 63);
    check("sat_row_d3", int'(s_out_costs[3*SAW +: SAW]), 0);
    check("sat_row_min", int'(s_out_min), 0);
    @(negedge clk);
    check("sat_valid", int'(s_out_valid), 1);
    check("sat_first", int'(s_out_first), 0);
`ifdef SGM_AGG_SATURATE_EN
    check("sat_d0", int'(s_out_costs[0 +: SAW]), 63);
    check("sat_d1", int'(s_out_costs[1*SAW +: SAW]), 63);
    check("sat_d2", int'(s_out_costs[2*SAW +: SAW]), 63);
    check("sat_d3", int'(s_out_costs[3*SAW +: SAW]), 63);
    check("sat_min", int'(s_out_min), 63);
`else
    check("wrap_d0", int'(s_out_costs[0 +: SAW]), 7);
    check("wrap_d1", int'(s_out_costs[1*SAW +: SAW]), 7);
    check("wrap_d2", int'(s_out_costs[2*SAW +: SAW]), 0);
    check("wrap_d3", int'(s_out_costs[3*SAW +: SAW]), 63);
    check("wrap_min", int'(s_out_min), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
